// File: rtl/sfifo_rd_if.sv
// Read-side adapter for a synchronous FIFO: two-entry (head + skid) buffer with a valid/ready output.
// Optional SFIFO_RDIF_CNT_EN adds a 32-bit accepted-transfer counter on xfer_cnt.
`ifndef RESET_SIG
`define RESET_SIG rst
`endif

module sfifo_rd_if #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_BITS = 3
) (
    input  logic                  clk,
    input  logic                  `RESET_SIG,
    input  logic                  fifo_empty,
    input  logic [WIDTH-1:0]      fifo_dout,
    input  logic [DEPTH_BITS:0]   fifo_count,
    output logic                  fifo_rd,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
`ifdef SFIFO_RDIF_CNT_EN
    output logic [31:0]           xfer_cnt,
`endif
    output logic [1:0]            occ
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   head_r;
    logic [WIDTH-1:0]   head_nxt_s;
    logic [WIDTH-1:0]   skid_r;
    logic [WIDTH-1:0]   skid_nxt_s;
    logic               out_valid_r;
    logic               rst_s;
    logic               rd_s;
    logic               accept_s;
    logic               unused_s;

    assign rst_s    = `RESET_SIG;
    // Occupancy is informational only; folded away so it is not left dangling.
    assign unused_s = ^fifo_count;

    // State, head and skid registers plus the registered valid flag.
    always_ff @(posedge clk) begin
        if (rst_s) begin
            state_r     <= S0;
            head_r      <= {WIDTH{1'b0}};
            skid_r      <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            head_r      <= head_nxt_s;
            skid_r      <= skid_nxt_s;
            out_valid_r <= (state_nxt_s != S0);
        end
    end

    // Next-state and data-path selection; flush wins over any pop or accept.
    always_comb begin
        state_nxt_s = state_r;
        head_nxt_s  = head_r;
        skid_nxt_s  = skid_r;
        case (state_r)
            S0: begin
                if (rd_s) begin
                    state_nxt_s = S1;
                    head_nxt_s  = fifo_dout;
                end else begin
                    state_nxt_s = S0;
                end
            end
            S1: begin
                if (rd_s && accept_s) begin
                    state_nxt_s = S1;
                    head_nxt_s  = fifo_dout;
                end else if (rd_s) begin
                    state_nxt_s = S2;
                    skid_nxt_s  = fifo_dout;
                end else if (accept_s) begin
                    state_nxt_s = S0;
                end else begin
                    state_nxt_s = S1;
                end
            end
            S2: begin
                if (accept_s) begin
                    state_nxt_s = S1;
                    head_nxt_s  = skid_r;
                end else begin
                    state_nxt_s = S2;
                end
            end
            default: begin
                state_nxt_s = S0;
            end
        endcase
        if (flush) begin
            state_nxt_s = S0;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Pop strobe and handshake; the pop never looks at out_ready so the FIFO side stays decoupled.
    always_comb begin
        rd_s     = !fifo_empty && !flush && (state_r != S2) && !rst_s;
        accept_s = out_valid_r && out_ready;
    end

    assign fifo_rd   = rd_s;
    assign out_valid = out_valid_r;
    assign out_data  = head_r;
    assign occ       = state_r;

`ifdef SFIFO_RDIF_CNT_EN
    logic [31:0] xfer_cnt_r;

    // Accepted-transfer counter; a flush-cycle handshake is not a transfer, and only reset clears it.
    always_ff @(posedge clk) begin
        if (rst_s) begin
            xfer_cnt_r <= 32'd0;
        end else if (accept_s && !flush) begin
            xfer_cnt_r <= xfer_cnt_r + 32'd1;
        end else begin
            xfer_cnt_r <= xfer_cnt_r;
        end
    end

    assign xfer_cnt = xfer_cnt_r;
`endif

endmodule

// File: tb/tb_sfifo_rd_if.sv
// Bench for sfifo_rd_if: directed vector table, then randomized traffic against a queue-based model.
`ifndef RESET_SIG
`define RESET_SIG rst
`endif

module tb_sfifo_rd_if;

    localparam int W  = 16;
    localparam int DB = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [W-1:0]  fifo_dout;
    logic [DB:0]   fifo_count;
    logic          flush;
    logic          out_ready;
    wire           fifo_rd;
    wire           out_valid;
    wire  [W-1:0]  out_data;
    wire  [1:0]    occ;
`ifdef SFIFO_RDIF_CNT_EN
    wire  [31:0]   xfer_cnt;
`endif

    always #5 clk = ~clk;

    sfifo_rd_if #(.WIDTH(W), .DEPTH_BITS(DB)) dut (
        .clk        (clk),
        .`RESET_SIG (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_count (fifo_count),
        .fifo_rd    (fifo_rd),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
`ifdef SFIFO_RDIF_CNT_EN
        .xfer_cnt   (xfer_cnt),
`endif
        .occ        (occ)
    );

    typedef struct {
        logic         rst;
        logic         empty;
        logic [W-1:0] dout;
        logic         flush;
        logic         ready;
        logic         exp_rd;
        logic [1:0]   exp_occ;
        logic         exp_valid;
        logic         chk_data;
        logic [W-1:0] exp_data;
        logic [31:0]  exp_cnt;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic [W-1:0] d, input logic f,
                                input logic rdy, input logic xrd, input logic [1:0] xocc,
                                input logic xv, input logic cd, input logic [W-1:0] xd,
                                input logic [31:0] xc);
        vec_t v;
        v.rst = r; v.empty = e; v.dout = d; v.flush = f; v.ready = rdy;
        v.exp_rd = xrd; v.exp_occ = xocc; v.exp_valid = xv; v.chk_data = cd;
        v.exp_data = xd; v.exp_cnt = xc;
        return v;
    endfunction

    vec_t          tv[$];
    logic [W-1:0]  fq[$];
    logic [W-1:0]  mq[$];
    logic [W-1:0]  next_word;
    logic [31:0]   macc;
    logic          exp_pop;
    logic          gap;

    initial begin
        rst = 1'b1; fifo_empty = 1'b1; fifo_dout = 16'h0000; fifo_count = 4'd0;
        flush = 1'b0; out_ready = 1'b0;

        //          rst   empty dout      flush rdy   rd    occ   vld   chkd  data      cnt
        tv.push_back(mk(1'b1, 1'b0, 16'h000A, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 16'h0000, 32'd0));
        // A,B,C streamed with out_ready high
        tv.push_back(mk(1'b0, 1'b0, 16'h000A, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 16'h000A, 32'd0));
        tv.push_back(mk(1'b0, 1'b0, 16'h000B, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 16'h000B, 32'd1));
        tv.push_back(mk(1'b0, 1'b0, 16'h000C, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 16'h000C, 32'd2));
        tv.push_back(mk(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0000, 32'd3));
        // back-pressure: only two pops, head held
        tv.push_back(mk(1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 16'h0010, 32'd3));
        tv.push_back(mk(1'b0, 1'b0, 16'h0011, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 16'h0010, 32'd3));
        tv.push_back(mk(1'b0, 1'b0, 16'h0012, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 16'h0010, 32'd3));
        tv.push_back(mk(1'b0, 1'b0, 16'h0012, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 16'h0010, 32'd3));
        // drain one from full, skid moves to head, then pop+accept keeps occ at 1
        tv.push_back(mk(1'b0, 1'b0, 16'h0012, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 16'h0011, 32'd4));
        tv.push_back(mk(1'b0, 1'b0, 16'h0012, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 16'h0012, 32'd5));
        tv.push_back(mk(1'b0, 1'b0, 16'h0013, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 16'h0012, 32'd5));
        // flush from full overrides accept and suppresses the pop
        tv.push_back(mk(1'b0, 1'b0, 16'h0014, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0000, 32'd5));
        tv.push_back(mk(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0000, 32'd5));
        // refill, then reset with two words held
        tv.push_back(mk(1'b0, 1'b0, 16'h0020, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 16'h0020, 32'd5));
        tv.push_back(mk(1'b0, 1'b0, 16'h0021, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 16'h0020, 32'd5));
        tv.push_back(mk(1'b1, 1'b0, 16'h0022, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 16'h0000, 32'd0));
        tv.push_back(mk(1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 16'h0030, 32'd0));

        foreach (tv[i]) begin
            @(negedge clk);
            rst = tv[i].rst; fifo_empty = tv[i].empty; fifo_dout = tv[i].dout;
            flush = tv[i].flush; out_ready = tv[i].ready;
            #1;
            chk($sformatf("vec%0d fifo_rd", i), {31'd0, fifo_rd}, {31'd0, tv[i].exp_rd});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d occ", i), {30'd0, occ}, {30'd0, tv[i].exp_occ});
            chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, tv[i].exp_valid});
            if (tv[i].chk_data) begin
                chk($sformatf("vec%0d out_data", i), {16'd0, out_data}, {16'd0, tv[i].exp_data});
            end else begin
                checks = checks;
            end
`ifdef SFIFO_RDIF_CNT_EN
            chk($sformatf("vec%0d xfer_cnt", i), xfer_cnt, tv[i].exp_cnt);
`endif
        end

        // Randomized traffic: bench owns a FIFO queue and an ordered list of words the adapter holds.
        next_word = 16'h1000;
        macc = 32'd0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (fq.size() < 8 && $urandom_range(0, 3) != 0) begin
                fq.push_back(next_word);
                next_word = next_word + 16'd1;
            end
            gap        = ($urandom_range(0, 3) == 0);
            rst        = (c == 0) || ($urandom_range(0, 999) == 0);
            flush      = ($urandom_range(0, 63) == 0);
            out_ready  = 1'($urandom_range(0, 1));
            fifo_empty = (fq.size() == 0) || gap;
            fifo_dout  = (fq.size() != 0) ? fq[0] : 16'($urandom);
            fifo_count = 4'(fq.size());
            exp_pop    = !fifo_empty && !flush && !rst && (mq.size() != 2);
            #1;
            chk("rand fifo_rd", {31'd0, fifo_rd}, {31'd0, exp_pop});
            if (c != 0) begin
                chk("rand occ", {30'd0, occ}, 32'(mq.size()));
                chk("rand out_valid", {31'd0, out_valid}, {31'd0, (mq.size() != 0)});
                if (mq.size() != 0) begin
                    chk("rand out_data", {16'd0, out_data}, {16'd0, mq[0]});
                end else begin
                    checks = checks;
                end
`ifdef SFIFO_RDIF_CNT_EN
                chk("rand xfer_cnt", xfer_cnt, macc);
`endif
            end else begin
                checks = checks;
            end
            @(posedge clk);
            #1;
            if (rst) begin
                mq.delete();
                macc = 32'd0;
            end else if (flush) begin
                mq.delete();
            end else begin
                if (mq.size() != 0 && out_ready) begin
                    void'(mq.pop_front());
                    macc = macc + 32'd1;
                end
                if (exp_pop) begin
                    mq.push_back(fq.pop_front());
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
